mem_wb_stage: RTL and testbench

Memory-access and write-back stage of the five-stage MIPS pipeline simulator, placed directly downstream of the execute stage. It consumes the execute stage's ALU result, store data and destination register. It performs word stores and multi-cycle word loads against an internal data memory. It presents a registered write-back triple (enable, register, result) to the register file. While a load is in flight it raises a stall so upstream stages hold their contents.

---
 rtl/mem_wb_stage_pkg.sv | 31 +++
 rtl/mem_wb_stage_data_memory.sv | 29 ++
 rtl/mem_wb_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory/write-back stage: FSM encodings, datapath
// widths, the write-back payload and the legal-range check on load latency.
package mem_wb_stage_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned LAT_MIN     = 1;
    localparam int unsigned LAT_MAX     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Write-back triple presented to the register file.
    typedef struct packed {
        logic              en;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_t;

    function automatic bit latency_ok(input int unsigned lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// Word-addressed data memory: synchronous write, combinational read.
// Ports: CLK; we/waddr/wdata write port; raddr/rdata read port.
// Contents are intentionally not reset.
module data_memory
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned DEPTH  = 512,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back pipeline stage.
// Accepts ALU results, word stores and multi-cycle word loads from execute and
// presents a registered write-back triple. StallM holds upstream while a load
// is pending.
// Ports:
//   CLK, RST_N                          clock, async active-low reset
//   MemWriteE, MemReadE, RegWriteE      operation controls from execute
//   WriteRegE, ALUOutE, WriteDataE      destination, address/result, store data
//   StallM                              combinational: load pending
//   RegWriteW, WriteRegW, ResultW       registered write-back triple
//   AlignErrM                           sticky misaligned-access flag
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 2,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              MemWriteE,
    input  logic              MemReadE,
    input  logic              RegWriteE,
    input  logic [REG_W-1:0]  WriteRegE,
    input  logic [DATA_W-1:0] ALUOutE,
    input  logic [DATA_W-1:0] WriteDataE,
    output logic              StallM,
    output logic              RegWriteW,
    output logic [REG_W-1:0]  WriteRegW,
    output logic [DATA_W-1:0] ResultW,
    output logic              AlignErrM
);

    // Elaboration-time parameter checks
    if (!latency_ok(LATENCY)) begin : g_bad_latency
        $error("mem_wb_stage: LATENCY out of range 1..8");
    end
    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("mem_wb_stage: DEPTH must be a power of two");
    end

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [ADDR_W-1:0] idx_q, idx_n;
    logic [REG_W-1:0]  rd_q, rd_n;
    logic              bad_q, bad_n;
    logic              align_q, align_n;
    wb_t               wb_q, wb_n;

    logic              mem_we_c;
    logic [ADDR_W-1:0] addr_idx_c;
    logic [ADDR_W-1:0] rd_idx_c;
    logic [DATA_W-1:0] rdata_c;
    logic              misalign_c;

    // Word index ignores byte offset and any bits beyond the memory size
    assign addr_idx_c = ALUOutE[ADDR_W+1:2];
    assign misalign_c = (ALUOutE[1:0] != 2'b00);

    // While waiting, read from the latched index so completion sees any later state
    assign rd_idx_c = (state_q == IDLE) ? addr_idx_c : idx_q;

    data_memory #(
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .we    (mem_we_c),
        .waddr (addr_idx_c),
        .wdata (WriteDataE),
        .raddr (rd_idx_c),
        .rdata (rdata_c)
    );

    // State and write-back registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rd_q    <= '0;
            bad_q   <= 1'b0;
            align_q <= 1'b0;
            wb_q    <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            rd_q    <= rd_n;
            bad_q   <= bad_n;
            align_q <= align_n;
            wb_q    <= wb_n;
        end
    end

    // Next-state, memory control and write-back selection
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        idx_n    = idx_q;
        rd_n     = rd_q;
        bad_n    = bad_q;
        align_n  = align_q;
        wb_n     = wb_q;
        wb_n.en  = 1'b0;
        mem_we_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (MemWriteE) begin
                    // Store wins over a simultaneous load; misaligned store is dropped
                    if (misalign_c) begin
                        align_n = 1'b1;
                    end else begin
                        mem_we_c = 1'b1;
                    end
                end else if (MemReadE) begin
                    if (misalign_c) begin
                        align_n = 1'b1;
                    end
                    idx_n = addr_idx_c;
                    rd_n  = WriteRegE;
                    bad_n = misalign_c;
                    if (LATENCY == 1) begin
                        wb_n.en   = RegWriteE;
                        wb_n.rd   = WriteRegE;
                        wb_n.data = misalign_c ? '0 : rdata_c;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    wb_n.en   = RegWriteE;
                    wb_n.rd   = WriteRegE;
                    wb_n.data = ALUOutE;
                end
            end
            WAIT: begin
                cnt_n = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_n   = IDLE;
                    wb_n.en   = 1'b1;
                    wb_n.rd   = rd_q;
                    wb_n.data = bad_q ? '0 : rdata_c;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Register 0 is never written
        if (wb_n.rd == '0) begin
            wb_n.en = 1'b0;
        end
    end

    assign StallM    = (state_q == WAIT);
    assign RegWriteW = wb_q.en;
    assign WriteRegW = wb_q.rd;
    assign ResultW   = wb_q.data;
    assign AlignErrM = align_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: one instance with LATENCY=2 and one with
// LATENCY=4 share the stimulus; the second is held in reset until its own phase.
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        rst2_n;
    logic        rst4_n;
    logic        MemWriteE;
    logic        MemReadE;
    logic        RegWriteE;
    logic [4:0]  WriteRegE;
    logic [31:0] ALUOutE;
    logic [31:0] WriteDataE;

    logic        stall2, rw2, ae2;
    logic [4:0]  wr2;
    logic [31:0] res2;
    logic        stall4, rw4, ae4;
    logic [4:0]  wr4;
    logic [31:0] res4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    mem_wb_stage #(.DEPTH(512), .LATENCY(2)) u2 (
        .CLK(CLK), .RST_N(rst2_n),
        .MemWriteE(MemWriteE), .MemReadE(MemReadE), .RegWriteE(RegWriteE),
        .WriteRegE(WriteRegE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
        .StallM(stall2), .RegWriteW(rw2), .WriteRegW(wr2), .ResultW(res2),
        .AlignErrM(ae2)
    );

    mem_wb_stage #(.DEPTH(512), .LATENCY(4)) u4 (
        .CLK(CLK), .RST_N(rst4_n),
        .MemWriteE(MemWriteE), .MemReadE(MemReadE), .RegWriteE(RegWriteE),
        .WriteRegE(WriteRegE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
        .StallM(stall4), .RegWriteW(rw4), .WriteRegW(wr4), .ResultW(res4),
        .AlignErrM(ae4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic mw, input logic mr, input logic rw,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d);
        MemWriteE  = mw;
        MemReadE   = mr;
        RegWriteE  = rw;
        WriteRegE  = rd;
        ALUOutE    = a;
        WriteDataE = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        rst2_n = 1'b0;
        rst4_n = 1'b0;
        idle();
        step();
        step();

        // Reset values
        chk("rst_stall",  32'(stall2), 32'h0);
        chk("rst_rw",     32'(rw2),    32'h0);
        chk("rst_wr",     32'(wr2),    32'h0);
        chk("rst_res",    res2,        32'h0);
        chk("rst_align",  32'(ae2),    32'h0);
        chk("rst4_res",   res4,        32'h0);

        rst2_n = 1'b1;

        // ALU pass-through
        drive(1'b0, 1'b0, 1'b1, 5'd8, 32'h1234, 32'h0);
        step();
        chk("alu_rw",    32'(rw2),    32'h1);
        chk("alu_wr",    32'(wr2),    32'd8);
        chk("alu_res",   res2,        32'h1234);
        chk("alu_stall", 32'(stall2), 32'h0);

        // Store then load on the next cycle (write-first)
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h40, 32'hDEADBEEF);
        step();
        chk("st_rw",    32'(rw2),    32'h0);
        chk("st_stall", 32'(stall2), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 5'd9, 32'h40, 32'h0);
        step();
        chk("ld_stall1", 32'(stall2), 32'h1);
        chk("ld_rw_wait", 32'(rw2),   32'h0);
        // Presented during WAIT: must be ignored then accepted once IDLE
        drive(1'b0, 1'b0, 1'b1, 5'd3, 32'h777, 32'h0);
        step();
        chk("ld_stall_end", 32'(stall2), 32'h0);
        chk("ld_rw",  32'(rw2),  32'h1);
        chk("ld_wr",  32'(wr2),  32'd9);
        chk("ld_res", res2,      32'hDEADBEEF);
        step();
        chk("held_alu_wr",  32'(wr2), 32'd3);
        chk("held_alu_res", res2,     32'h777);

        // Address wrap: 0x800 is word 512 -> word 0
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h800, 32'h5);
        step();
        drive(1'b0, 1'b1, 1'b1, 5'd10, 32'h0, 32'h0);
        step();
        chk("wrap_stall", 32'(stall2), 32'h1);
        idle();
        step();
        chk("wrap_res", res2,     32'h5);
        chk("wrap_wr",  32'(wr2), 32'd10);
        chk("wrap_rw",  32'(rw2), 32'h1);

        // Misaligned store is suppressed and flags sticky error
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h42, 32'h11111111);
        step();
        chk("mis_st_align", 32'(ae2), 32'h1);
        drive(1'b0, 1'b1, 1'b1, 5'd11, 32'h40, 32'h0);
        step();
        idle();
        step();
        chk("mis_st_keep", res2,     32'hDEADBEEF);
        chk("align_sticky", 32'(ae2), 32'h1);

        // Misaligned load still stalls and returns 0
        drive(1'b0, 1'b1, 1'b1, 5'd12, 32'h41, 32'h0);
        step();
        chk("mis_ld_stall", 32'(stall2), 32'h1);
        idle();
        step();
        chk("mis_ld_res", res2,     32'h0);
        chk("mis_ld_rw",  32'(rw2), 32'h1);

        // Load into register 0
        drive(1'b0, 1'b1, 1'b1, 5'd0, 32'h40, 32'h0);
        step();
        chk("r0_stall", 32'(stall2), 32'h1);
        idle();
        step();
        chk("r0_rw",    32'(rw2),    32'h0);
        chk("r0_res",   res2,        32'hDEADBEEF);
        chk("r0_stall_end", 32'(stall2), 32'h0);

        // Store and load together: store wins
        drive(1'b1, 1'b1, 1'b1, 5'd13, 32'h44, 32'hCAFEF00D);
        step();
        chk("both_stall", 32'(stall2), 32'h0);
        chk("both_rw",    32'(rw2),    32'h0);
        drive(1'b0, 1'b1, 1'b1, 5'd14, 32'h44, 32'h0);
        step();
        idle();
        step();
        chk("both_res", res2, 32'hCAFEF00D);

        // ALU op to register 0
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h99, 32'h0);
        step();
        chk("alu_r0_rw",  32'(rw2), 32'h0);
        chk("alu_r0_res", res2,     32'h99);

        // LATENCY=4 instance: reset mid-load, then a complete load
        chk("rst4_stall", 32'(stall4), 32'h0);
        rst4_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h80, 32'h12345678);
        step();
        drive(1'b0, 1'b1, 1'b1, 5'd15, 32'h80, 32'h0);
        step();
        chk("l4_stall_a", 32'(stall4), 32'h1);
        idle();
        step();
        chk("l4_stall_b", 32'(stall4), 32'h1);
        rst4_n = 1'b0;
        #1;
        chk("l4_rst_stall", 32'(stall4), 32'h0);
        chk("l4_rst_rw",    32'(rw4),    32'h0);
        step();
        rst4_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("l4_no_pulse", 32'(rw4), 32'h0);
        end
        drive(1'b0, 1'b1, 1'b1, 5'd16, 32'h80, 32'h0);
        step();
        idle();
        chk("l4_stall_1", 32'(stall4), 32'h1);
        step();
        chk("l4_stall_2", 32'(stall4), 32'h1);
        step();
        chk("l4_stall_3", 32'(stall4), 32'h1);
        chk("l4_rw_wait", 32'(rw4),    32'h0);
        step();
        chk("l4_done_stall", 32'(stall4), 32'h0);
        chk("l4_rw",  32'(rw4),  32'h1);
        chk("l4_wr",  32'(wr4),  32'd16);
        chk("l4_res", res4,      32'h12345678);
        chk("l4_align", 32'(ae4), 32'h0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
